conv_mac_engine: RTL and testbench

- Sequencing and multiply-accumulate stage of the convolution core.
- Sits downstream of two `simple_ram_block` instances: the signal RAM `x` and the kernel RAM `h`.
- On `start_i` it drives both RAMs' read addresses, consumes their 1-cycle-latency read data, and computes the full linear convolution `y[n] = Σ x[k]·h[n−k]`.
- Each finished `y[n]` is written through a RAM-style write port into a result `simple_ram_block`.

---
 rtl/conv_mac_engine_pkg.sv | 24 ++
 rtl/conv_mac_engine_mac.sv | 40 ++++
 rtl/conv_mac_engine.sv | 153 +++++++++++++++
 tb/tb_conv_mac_engine.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_mac_engine_pkg.sv
// Shared types and helper functions for the convolution MAC engine:
// FSM state encoding, accumulator width rule and operand-length clamp.
package conv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MAC   = 3'd1,
    ST_FLUSH = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } conv_state_t;

  // Product width plus enough headroom for 2**aw terms, plus one spare bit.
  function automatic int acc_width(input int dw, input int aw);
    return 2 * dw + aw + 1;
  endfunction

  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned aw);
    int unsigned max_len;
    max_len = 32'd1 << aw;
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/conv_mac_engine_mac.sv
// Registered unsigned multiply-accumulate; clear has priority over enable.
module conv_mac #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 22
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_i,
  input  logic                  en_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [ACC_WIDTH-1:0]  acc_o
);

  logic [ACC_WIDTH-1:0]    acc_q;
  logic [ACC_WIDTH-1:0]    acc_d;
  logic [2*DATA_WIDTH-1:0] prod;

  assign prod = a_i * b_i;

  always_comb begin
    acc_d = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + ACC_WIDTH'(prod);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/conv_mac_engine.sv
// Sequences x/h RAM reads for a full linear convolution, accumulates each
// y[n] through a one-deep read pipeline and emits it on a RAM write port.
module conv_mac_engine
  import conv_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int ADDR_WIDTH = 5,
  localparam int ACC_WIDTH  = acc_width(DATA_WIDTH, ADDR_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH:0]   size_x_i,
  input  logic [ADDR_WIDTH:0]   size_h_i,
  output logic [ADDR_WIDTH-1:0] x_addr_o,
  input  logic [DATA_WIDTH-1:0] x_data_i,
  output logic [ADDR_WIDTH-1:0] h_addr_o,
  input  logic [DATA_WIDTH-1:0] h_data_i,
  output logic                  y_we_o,
  output logic [ADDR_WIDTH:0]   y_addr_o,
  output logic [ACC_WIDTH-1:0]  y_data_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int LEN_W = ADDR_WIDTH + 1;
  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);
  localparam logic [LEN_W-1:0] TWO = LEN_W'(2);

  conv_state_t state_q, state_d;
  logic [LEN_W-1:0]      lx_q, lx_d, lh_q, lh_d, n_q, n_d;
  logic [ADDR_WIDTH-1:0] x_addr_q, x_addr_d, h_addr_q, h_addr_d;
  logic                  valid_q, busy_q, done_q, we_q;
  logic [LEN_W-1:0]      kmax_w, n_next_w, kmin_next_w, n_last_w;
  logic                  mac_clear;
  logic [ACC_WIDTH-1:0]  acc;

  function automatic logic [LEN_W-1:0] kmin_f(input logic [LEN_W-1:0] n,
                                               input logic [LEN_W-1:0] lh);
    return (n + ONE > lh) ? (n + ONE - lh) : '0;
  endfunction

  function automatic logic [LEN_W-1:0] kmax_f(input logic [LEN_W-1:0] n,
                                               input logic [LEN_W-1:0] lx);
    return (n < lx - ONE) ? n : (lx - ONE);
  endfunction

  assign kmax_w      = kmax_f(n_q, lx_q);
  assign n_next_w    = n_q + ONE;
  assign kmin_next_w = kmin_f(n_next_w, lh_q);
  // Modulo-2**LEN_W arithmetic still lands on the right index when Lx+Lh overflows.
  assign n_last_w    = lx_q + lh_q - TWO;

  // start_i is a bare one-cycle request: no ready, sampled only in IDLE and
  // dropped everywhere else.
  always_comb begin
    state_d  = state_q;
    lx_d     = lx_q;
    lh_d     = lh_q;
    n_d      = n_q;
    x_addr_d = x_addr_q;
    h_addr_d = h_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          lx_d = LEN_W'(clamp_len(32'(size_x_i), ADDR_WIDTH));
          lh_d = LEN_W'(clamp_len(32'(size_h_i), ADDR_WIDTH));
          if (size_x_i == '0 || size_h_i == '0) begin
            state_d = ST_DONE;
          end else begin
            n_d      = '0;
            x_addr_d = '0;
            h_addr_d = '0;
            state_d  = ST_MAC;
          end
        end
      end
      ST_MAC: begin
        if (x_addr_q == kmax_w[ADDR_WIDTH-1:0]) begin
          state_d = ST_FLUSH;
        end else begin
          x_addr_d = x_addr_q + 1'b1;
          h_addr_d = h_addr_q - 1'b1;
        end
      end
      ST_FLUSH: state_d = ST_WRITE;
      ST_WRITE: begin
        if (n_q == n_last_w) begin
          state_d = ST_DONE;
        end else begin
          n_d      = n_next_w;
          x_addr_d = kmin_next_w[ADDR_WIDTH-1:0];
          h_addr_d = ADDR_WIDTH'(n_next_w - kmin_next_w);
          state_d  = ST_MAC;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      lx_q     <= '0;
      lh_q     <= '0;
      n_q      <= '0;
      x_addr_q <= '0;
      h_addr_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      we_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      lx_q     <= lx_d;
      lh_q     <= lh_d;
      n_q      <= n_d;
      x_addr_q <= x_addr_d;
      h_addr_q <= h_addr_d;
      // Read data for an address issued now arrives next cycle.
      valid_q  <= (state_q == ST_MAC);
      busy_q   <= (state_d == ST_MAC) || (state_d == ST_FLUSH) || (state_d == ST_WRITE);
      done_q   <= (state_d == ST_DONE);
      we_q     <= (state_d == ST_WRITE);
    end
  end

  // Accumulator is zeroed while idle and during WRITE, ready for the next y[n].
  assign mac_clear = (state_q == ST_IDLE) || (state_q == ST_WRITE);

  conv_mac #(
    .DATA_WIDTH(DATA_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_mac (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear_i(mac_clear),
    .en_i   (valid_q),
    .a_i    (x_data_i),
    .b_i    (h_data_i),
    .acc_o  (acc)
  );

  assign x_addr_o = x_addr_q;
  assign h_addr_o = h_addr_q;
  assign y_we_o   = we_q;
  assign y_addr_o = n_q;
  assign y_data_o = we_q ? acc : '0;
  assign busy_o   = busy_q;
  assign done_o   = done_q;

endmodule

// File: tb/tb_conv_mac_engine.sv
// Bench for conv_mac_engine: behavioural x/h/result RAMs, a direct-sum
// convolution model feeding an expected queue, vector table plus corner sequences.
module tb_conv_mac_engine;

  localparam int DW   = 8;
  localparam int AW   = 5;
  localparam int ACCW = 2 * DW + AW + 1;
  localparam int LW   = AW + 1;
  localparam int MAXL = 1 << AW;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start_i;
  logic [LW-1:0]   size_x_i, size_h_i;
  logic [AW-1:0]   x_addr_o, h_addr_o;
  logic [DW-1:0]   x_data_i, h_data_i;
  logic            y_we_o, busy_o, done_o;
  logic [LW-1:0]   y_addr_o;
  logic [ACCW-1:0] y_data_o;

  always #5 clk = ~clk;

  conv_mac_engine #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start_i),
    .size_x_i(size_x_i),
    .size_h_i(size_h_i),
    .x_addr_o(x_addr_o),
    .x_data_i(x_data_i),
    .h_addr_o(h_addr_o),
    .h_data_i(h_data_i),
    .y_we_o  (y_we_o),
    .y_addr_o(y_addr_o),
    .y_data_o(y_data_o),
    .busy_o  (busy_o),
    .done_o  (done_o)
  );

  logic [DW-1:0]      x_mem [MAXL];
  logic [DW-1:0]      h_mem [MAXL];
  logic [ACCW-1:0]    res_mem [2*MAXL];
  logic [LW+ACCW-1:0] exp_q [$];
  logic [LW+ACCW-1:0] exp_e;

  int checks = 0;
  int errors = 0;
  int writes_seen = 0;

  // Source RAMs with one-cycle read latency.
  always_ff @(posedge clk) begin
    x_data_i <= x_mem[x_addr_o];
    h_data_i <= h_mem[h_addr_o];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Result-port scoreboard.
  always @(negedge clk) begin
    if (rst_n && y_we_o) begin
      writes_seen++;
      res_mem[y_addr_o] = y_data_o;
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 1, 0);
      end else begin
        exp_e = exp_q.pop_front();
        chk("y_addr", 64'(y_addr_o), 64'(exp_e[LW+ACCW-1:ACCW]));
        chk("y_data", 64'(y_data_o), 64'(exp_e[ACCW-1:0]));
      end
    end
  end

  // Direct sum over every (k, j) pair with k + j == n.
  function automatic void build_exp(input int lx, input int lh);
    longint acc;
    exp_q.delete();
    for (int n = 0; n <= lx + lh - 2; n++) begin
      acc = 0;
      for (int k = 0; k < lx; k++) begin
        if (n - k >= 0 && n - k < lh) acc += longint'(x_mem[k]) * longint'(h_mem[n - k]);
      end
      exp_q.push_back({LW'(n), ACCW'(acc)});
    end
  endfunction

  function automatic int clampl(input int s);
    return (s > MAXL) ? MAXL : s;
  endfunction

  task automatic fill(input int mode);
    for (int i = 0; i < MAXL; i++) begin
      x_mem[i] = DW'($urandom_range(0, 255));
      h_mem[i] = DW'($urandom_range(0, 255));
    end
    if (mode == 0) begin
      x_mem[0] = 1; x_mem[1] = 2; x_mem[2] = 3;
      h_mem[0] = 1; h_mem[1] = 1;
    end else if (mode == 1) begin
      for (int i = 0; i < MAXL; i++) begin
        x_mem[i] = 8'd255;
        h_mem[i] = 8'd255;
      end
    end else if (mode == 2) begin
      x_mem[0] = 7;
      h_mem[0] = 1; h_mem[1] = 2; h_mem[2] = 3; h_mem[3] = 4;
    end
  endtask

  // Entered and left at a negedge in an IDLE cycle, so consecutive calls are back-to-back.
  task automatic run_job(input int sx, input int sh, input int exp_busy, input bit mid_start);
    int lx, lh, exp_writes, cyc, busy_cnt, done_cyc;
    bit busy_at_done;
    lx = clampl(sx);
    lh = clampl(sh);
    exp_writes = (lx > 0 && lh > 0) ? lx + lh - 1 : 0;
    if (exp_writes > 0) build_exp(lx, lh);
    else exp_q.delete();
    writes_seen = 0;
    size_x_i = LW'(sx);
    size_h_i = LW'(sh);
    start_i  = 1'b1;
    @(negedge clk);
    start_i  = 1'b0;
    size_x_i = LW'($urandom);
    size_h_i = LW'($urandom);
    cyc = 0; busy_cnt = 0; done_cyc = 0; busy_at_done = 1'b1;
    while (cyc < exp_busy + 40) begin
      cyc++;
      if (busy_o) busy_cnt++;
      if (done_o) begin
        done_cyc = cyc;
        busy_at_done = busy_o;
        break;
      end
      start_i = (mid_start && (cyc == 5 || cyc == 9));
      @(negedge clk);
    end
    start_i = 1'b0;
    chk("done_cycle", 64'(done_cyc), 64'(exp_busy + 1));
    chk("busy_cycles", 64'(busy_cnt), 64'(exp_busy));
    chk("busy_at_done", 64'(busy_at_done), 0);
    chk("write_count", 64'(writes_seen), 64'(exp_writes));
    chk("exp_q_drained", 64'(exp_q.size()), 0);
    @(negedge clk);
    chk("done_pulse_len", 64'(done_o), 0);
  endtask

  typedef struct {
    int sx;
    int sh;
    int mode;
    int exp_busy;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int lx, lh;
    vecs[0] = '{sx: 3,  sh: 2,  mode: 0, exp_busy: 14};
    vecs[1] = '{sx: 32, sh: 32, mode: 1, exp_busy: 1150};
    vecs[2] = '{sx: 1,  sh: 4,  mode: 2, exp_busy: 12};
    vecs[3] = '{sx: 4,  sh: 0,  mode: 3, exp_busy: 0};
    vecs[4] = '{sx: 0,  sh: 5,  mode: 3, exp_busy: 0};
    vecs[5] = '{sx: 40, sh: 2,  mode: 3, exp_busy: 130};
    vecs[6] = '{sx: 40, sh: 40, mode: 1, exp_busy: 1150};
    vecs[7] = '{sx: 5,  sh: 3,  mode: 3, exp_busy: 29};
    vecs[8] = '{sx: 1,  sh: 1,  mode: 3, exp_busy: 3};

    rst_n = 1'b0; start_i = 1'b0; size_x_i = '0; size_h_i = '0;
    fill(3);
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy_o), 0);
    chk("rst_done", 64'(done_o), 0);
    chk("rst_we", 64'(y_we_o), 0);
    chk("rst_y_addr", 64'(y_addr_o), 0);
    chk("rst_y_data", 64'(y_data_o), 0);
    chk("rst_x_addr", 64'(x_addr_o), 0);
    chk("rst_h_addr", 64'(h_addr_o), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      fill(vecs[i].mode);
      run_job(vecs[i].sx, vecs[i].sh, vecs[i].exp_busy, 1'b0);
      if (vecs[i].mode == 0) begin
        chk("t1_y0", 64'(res_mem[0]), 1);
        chk("t1_y1", 64'(res_mem[1]), 3);
        chk("t1_y2", 64'(res_mem[2]), 5);
        chk("t1_y3", 64'(res_mem[3]), 3);
      end else if (vecs[i].mode == 1) begin
        chk("max_y0", 64'(res_mem[0]), 65025);
        chk("max_y31", 64'(res_mem[31]), 2080800);
        chk("max_y62", 64'(res_mem[62]), 65025);
      end else if (vecs[i].mode == 2) begin
        chk("k_y0", 64'(res_mem[0]), 7);
        chk("k_y1", 64'(res_mem[1]), 14);
        chk("k_y2", 64'(res_mem[2]), 21);
        chk("k_y3", 64'(res_mem[3]), 28);
      end
    end

    // Start pulses mid-job must not disturb the running job.
    fill(0);
    run_job(3, 2, 14, 1'b1);
    fill(3);
    run_job(6, 7, 42 + 24, 1'b1);

    // Randomized jobs against the model.
    for (int j = 0; j < 12; j++) begin
      lx = $urandom_range(1, 12);
      lh = $urandom_range(1, 12);
      fill(3);
      run_job(lx, lh, lx * lh + 2 * (lx + lh - 1), ($urandom_range(0, 3) == 0));
    end

    // Reset while accumulating y[2] of the x={1,2,3}, h={1,1} job (cycles 8-9).
    fill(0);
    build_exp(3, 2);
    writes_seen = 0;
    size_x_i = 3; size_h_i = 2; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (7) @(negedge clk);
    chk("pre_rst_writes", 64'(writes_seen), 2);
    chk("pre_rst_busy", 64'(busy_o), 1);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_rst_busy", 64'(busy_o), 0);
    chk("mid_rst_done", 64'(done_o), 0);
    chk("mid_rst_we", 64'(y_we_o), 0);
    chk("mid_rst_y_addr", 64'(y_addr_o), 0);
    chk("mid_rst_y_data", 64'(y_data_o), 0);
    chk("mid_rst_x_addr", 64'(x_addr_o), 0);
    chk("mid_rst_h_addr", 64'(h_addr_o), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    writes_seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (busy_o || done_o) chk("post_rst_idle", {busy_o, done_o}, 0);
    end
    chk("post_rst_writes", 64'(writes_seen), 0);
    run_job(3, 2, 14, 1'b0);
    chk("rerun_y2", 64'(res_mem[2]), 5);
    chk("rerun_y3", 64'(res_mem[3]), 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
